uart_recv: RTL and testbench

UART receive stage for the RS232 loopback path. It oversamples the asynchronous `uart_rxd` line and reassembles 8N1 frames (LSB first). Each valid byte is presented on `uart_data`, together with a one-cycle `uart_done` strobe. The outputs drive `uart_send.data` and `uart_send.uart_done` directly.

---
 rtl/uart_recv_if.sv | 16 +
 rtl/uart_recv.sv | 88 ++++++++
 tb/tb_uart_recv.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_recv_if.sv
// uart_recv_if: serial input line and received-byte outputs of the UART receiver
// Signals:
//   uart_rxd   serial line into the receiver (idles high)
//   uart_data  last correctly received byte
//   uart_done  one-cycle strobe, uart_data updated
//   frame_err  one-cycle strobe, stop bit sampled low and byte discarded
// Modports: slave = receiver side, master = line driver / byte consumer side
`timescale 1ns/1ps
interface uart_recv_if;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    modport master (output uart_rxd, input uart_data, uart_done, frame_err);
    modport slave  (input uart_rxd, output uart_data, uart_done, frame_err);
endinterface

// File: rtl/uart_recv.sv
// uart_recv: oversampling 8N1 UART receiver, LSB first
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_recv_if.slave: uart_rxd in; uart_data, uart_done, frame_err out
`timescale 1ns/1ps
module uart_recv #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_recv_if.slave        bus
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d, data_q, data_d;
    logic        done_q, done_d, err_q, err_d;
    logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic        neg;
    assign neg = rxd_s3_q & ~rxd_s2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rxd_s1_q <= bus.uart_rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    // Counter free-runs in every active state and is cleared at each sample point.
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: state_d = neg ? START : IDLE;
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                state_d = rxd_s2_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == BPS_LAST) begin
                cnt_d          = 16'd0;
                shift_d[idx_q] = rxd_s2_q;
                idx_d          = idx_q + 3'd1;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == BPS_LAST) begin
                cnt_d   = 16'd0;
                done_d  = rxd_s2_q;
                err_d   = ~rxd_s2_q;
                data_d  = rxd_s2_q ? shift_q : data_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.uart_data = data_q;
    assign bus.uart_done = done_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: randomized and directed frames against a byte/strobe reference model
`timescale 1ns/1ps
module tb_uart_recv;
    localparam int  BPS = 434;
    localparam int  HALF = 217;
    localparam int  LAT = HALF + 9 * BPS + 3;
    localparam real BIT_NS = 8680.0;
    typedef struct {int cyc; logic [7:0] data; logic done; logic err;} ev_t;
    typedef struct {int cyc; logic [7:0] data; logic stop; logic timed;} fr_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    ev_t obs[$];
    fr_t exp_q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] sk_b [3] = '{8'h00, 8'hFF, 8'h6B};
    uart_recv_if bus();
    uart_recv dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (bus.uart_done || bus.frame_err)
            obs.push_back('{cyc, bus.uart_data, bus.uart_done, bus.frame_err});
    end
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask
    task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
        n_chk++;
        assert (v >= lo && v <= hi) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, v, lo, hi);
        end
    endtask
    // Drives one 8N1 frame; rec queues it for the model, timed enables the latency check.
    task automatic send(input logic [7:0] b, input real bit_ns, input logic stop, input bit rec, input bit timed);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        if (rec) exp_q.push_back('{cyc, b, stop, timed});
        for (int i = 0; i < 10; i++) begin
            bus.uart_rxd = fr[i];
            #(bit_ns);
        end
        bus.uart_rxd = 1'b1;
    endtask
    // Model: a good stop bit updates the held byte with a done strobe, a bad one strobes
    // frame_err and keeps the previous byte; strobe follows the line fall by LAT cycles.
    task automatic drain(input string tag);
        repeat (20) @(posedge clk);
        #2;
        chk({tag, ":events"}, obs.size(), exp_q.size());
        while (exp_q.size() > 0 && obs.size() > 0) begin
            fr_t f;
            ev_t e;
            f = exp_q.pop_front();
            e = obs.pop_front();
            if (f.stop) last_good = f.data;
            chk({tag, ":done"}, e.done, f.stop);
            chk({tag, ":err"}, e.err, !f.stop);
            chk({tag, ":data"}, e.data, last_good);
            if (f.timed) chk_rng({tag, ":lat"}, e.cyc - f.cyc, LAT - 1, LAT + 1);
        end
        exp_q.delete();
        obs.delete();
    endtask
    initial begin
        bus.uart_rxd = 1'b1;
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_data", bus.uart_data, 8'h00);
        chk("rst_done", bus.uart_done, 1'b0);
        chk("rst_err", bus.frame_err, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h55, BIT_NS, 1'b1, 1'b1, 1'b1);
        drain("f55");
        @(negedge clk);
        send(8'hA5, BIT_NS, 1'b1, 1'b1, 1'b1);
        send(8'h3C, BIT_NS, 1'b1, 1'b1, 1'b1);
        drain("b2b");
        @(negedge clk);
        send(8'h81, BIT_NS, 1'b0, 1'b1, 1'b1);
        drain("ferr");
        @(negedge clk);
        bus.uart_rxd = 1'b0;
        #100;
        bus.uart_rxd = 1'b1;
        repeat (600) @(posedge clk);
        drain("glitch");
        @(negedge clk);
        send(8'h0F, BIT_NS, 1'b1, 1'b1, 1'b1);
        drain("f0f");
        @(negedge clk);
        fork
            send(8'hFF, BIT_NS, 1'b1, 1'b0, 1'b0);
            begin
                #(BIT_NS * 5.5);
                rst_n = 1'b0;
                #1000;
                rst_n = 1'b1;
            end
        join
        last_good = 8'h00;
        #100;
        chk("rst_mid_data", bus.uart_data, last_good);
        drain("rst_mid");
        @(negedge clk);
        send(8'h12, BIT_NS, 1'b1, 1'b1, 1'b1);
        drain("f12");
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                repeat (50) @(negedge clk);
                send(sk_b[j], BIT_NS / (k == 0 ? 1.03 : 0.97), 1'b1, 1'b1, 1'b0);
                drain(k == 0 ? "fast" : "slow");
            end
        end
        for (int r = 0; r < 3; r++) begin
            logic [7:0] b;
            logic       stop;
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(5, 60)) @(negedge clk);
            send(b, BIT_NS, stop, 1'b1, 1'b1);
            drain("rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
